// File: rtl/ser2par_pkg.sv
// Shared definitions for the serial-to-parallel deframer.
package ser2par_pkg;

    localparam bit LANE_ORDER_LSB = 1'b0;
    localparam bit LANE_ORDER_MSB = 1'b1;

    // Ceiling log2, never less than 1 so that a slot index always has a bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ser2par_slot_ctr.sv
// Slot counter for the deframer: tracks the next sample slot, flags the
// final slot of a word and decodes the slot into a one-hot lane write.
module ser2par_slot_ctr
    import ser2par_pkg::*;
#(
    parameter  int LANES = 4,
    localparam int SW    = clog2(LANES)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             SOF,
    output logic [SW-1:0]    SLOT,
    output logic             LAST,
    output logic [LANES-1:0] SLOT_WE
);

    localparam logic [SW-1:0] LAST_SLOT = SW'(LANES - 1);

    logic [SW-1:0] slot_q;
    logic [SW-1:0] slot_d;
    logic [SW-1:0] eff_slot;

    // A start-of-frame sample always lands in slot 0, abandoning any partial word.
    always_comb begin
        eff_slot = SOF ? '0 : slot_q;
        slot_d   = slot_q;
        LAST     = 1'b0;
        SLOT_WE  = '0;
        if (EN) begin
            if (eff_slot == LAST_SLOT) begin
                slot_d = '0;
                LAST   = 1'b1;
            end else begin
                slot_d = eff_slot + 1'b1;
            end
            for (int k = 0; k < LANES; k++) begin
                if (eff_slot == SW'(k)) SLOT_WE[k] = 1'b1;
            end
        end
    end

    // Slot register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) slot_q <= '0;
        else     slot_q <= slot_d;
    end

    assign SLOT = slot_q;

endmodule

// File: rtl/ser2par_deframer.sv
// Serial-to-parallel deframer: gathers LANES samples of WIDTH bits into one
// word, presents it with valid/ready, and flags words dropped on overrun.
module ser2par_deframer
    import ser2par_pkg::*;
#(
    parameter  int WIDTH     = 1,
    parameter  int LANES     = 4,
    parameter  bit MSB_FIRST = LANE_ORDER_LSB,
    localparam int SW        = clog2(LANES)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic [WIDTH-1:0]       DIN,
    input  logic                   SOF,
    output logic [LANES*WIDTH-1:0] Y,
    output logic                   Y_VALID,
    input  logic                   Y_READY,
    output logic                   OVERRUN,
    input  logic                   CLR_OVR,
    output logic [SW-1:0]          SLOT
);

    logic [LANES-1:0]       slot_we;
    logic [LANES-1:0]       lane_we;
    logic                   last;
    logic [LANES*WIDTH-1:0] cap_q, cap_d;
    logic [LANES*WIDTH-1:0] y_q, y_d;
    logic                   vld_q, vld_d;
    logic                   ovr_q, ovr_d;

    ser2par_slot_ctr #(.LANES(LANES)) u_slot_ctr (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .SOF     (SOF),
        .SLOT    (SLOT),
        .LAST    (last),
        .SLOT_WE (slot_we)
    );

    // Map slot order to lane order; MSB-first mirrors the lane index.
    always_comb begin
        lane_we = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_we[k] = (MSB_FIRST == LANE_ORDER_MSB) ? slot_we[LANES-1-k] : slot_we[k];
        end
    end

    // Merge the incoming sample into its lane; the merged value is also the completed word.
    always_comb begin
        cap_d = cap_q;
        for (int k = 0; k < LANES; k++) begin
            if (lane_we[k]) cap_d[k*WIDTH +: WIDTH] = DIN;
        end
    end

    // Output register and overrun: load on completion if the slot is free or being
    // consumed, otherwise drop the word. A fresh overrun beats a clear in the same cycle.
    always_comb begin
        y_d   = y_q;
        vld_d = vld_q;
        ovr_d = ovr_q & ~CLR_OVR;
        if (last) begin
            if (!vld_q || Y_READY) begin
                y_d   = cap_d;
                vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (vld_q && Y_READY) begin
            vld_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cap_q <= '0;
            y_q   <= '0;
            vld_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            cap_q <= cap_d;
            y_q   <= y_d;
            vld_q <= vld_d;
            ovr_q <= ovr_d;
        end
    end

    assign Y       = y_q;
    assign Y_VALID = vld_q;
    assign OVERRUN = ovr_q;

endmodule

// File: doc/ser2par_deframer.md
Name: ser2par_deframer

Overview:
- Parametrised serial-to-parallel converter: the next generation of the team's counter/decoder/latch demux.
- Collects LANES consecutive WIDTH-bit serial samples into one parallel word.
- Presents the word on a registered output with valid/ready handshake.
- Adds frame resync, bit-order mode and overrun detection; sits between a serial ingress stream and a parallel downstream consumer.

Parameters:
- WIDTH, 1, bits per serial sample (>=1).
- LANES, 4, samples per parallel word (>=2, power of two not required).
- MSB_FIRST, 0, 0: first sample of a frame lands in lane 0; 1: first sample lands in lane LANES-1.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  serial sample valid; DIN is sampled only when EN=1.
- DIN  in  WIDTH  serial sample.
- SOF  in  1  start-of-frame; qualified by EN.
- Y  out  LANES*WIDTH  parallel word; lane k = Y[k*WIDTH +: WIDTH].
- Y_VALID  out  1  Y holds an unconsumed word.
- Y_READY  in  1  consumer accepts Y when Y_VALID=1.
- OVERRUN  out  1  sticky flag: a completed word was dropped.
- CLR_OVR  in  1  synchronous clear of OVERRUN.
- SLOT  out  clog2(LANES)  index of the next sample slot (debug).

Behaviour:
- Reset (async, RST=1): SLOT=0, capture buffer=0, Y=0, Y_VALID=0, OVERRUN=0. Any partial word is discarded.
- Slot counter:
  - Advances only on an accepted sample (EN=1).
  - Wraps LANES-1 -> 0 (no 2^n assumption; explicit compare to LANES-1).
  - EN=0: counter and buffer hold.
- Capture: on EN=1, DIN is written into capture lane L.
  - L = SLOT when MSB_FIRST=0.
  - L = LANES-1-SLOT when MSB_FIRST=1.
  - Other lanes are unchanged.
- SOF (EN=1 and SOF=1):
  - The current sample is forced into slot 0; SLOT becomes 1 next cycle.
  - Any partial word is abandoned; abandoned lanes are not cleared and are overwritten as the frame fills.
  - SOF with EN=0 is ignored.
- Completion: a sample accepted into slot LANES-1 completes a word. The complete word is {capture buffer with this sample merged}.
- Output register, evaluated each cycle in this priority:
  - Completion and (Y_VALID=0 or Y_READY=1): Y <= complete word, Y_VALID <= 1. Latency is one clock from the final sample's edge.
  - Completion and Y_VALID=1 and Y_READY=0: new word dropped, Y unchanged, OVERRUN <= 1.
  - No completion and Y_VALID=1 and Y_READY=1: Y_VALID <= 0, Y holds its last value.
  - Simultaneous accept and completion: Y reloads and Y_VALID stays 1 (back-to-back, no bubble).
- OVERRUN:
  - CLR_OVR=1 clears it.
  - A new overrun event in the same cycle wins, so OVERRUN stays 1.
- Y_READY is ignored while Y_VALID=0.
- Y changes only on load. It is stable while Y_VALID=1 and Y_READY=0.
- Sustained throughput: one word per LANES samples. No internal backpressure on the serial side; dropping is the only overflow policy.

Decomposition:
- Shared package ser2par_pkg:
  - Function clog2 for the SLOT width.
  - Constants for the MSB_FIRST encodings (LANE_ORDER_LSB=0, LANE_ORDER_MSB=1).
- One sub-module, ser2par_slot_ctr:
  - Parametrised by LANES.
  - Inputs CLK, RST, EN, SOF.
  - Outputs SLOT and a 'last' strobe (EN & slot==LANES-1, or LANES-1==0 never).
  - It also produces the lane-write decode (one-hot, LANES bits).
- Capture, output register and overrun logic stay in the top.

Test Plan (WIDTH=1, LANES=4 unless noted):
1. Reset, then EN=1 with DIN=1,0,1,1 on 4 cycles and Y_READY=1 -> Y=4'b1101 with Y_VALID=1 one cycle after the 4th edge; Y_VALID drops the next cycle; SLOT returns to 0.
2. MSB_FIRST=1, same stream -> Y=4'b1011.
3. Y_READY=0, stream 8 samples (word A=0xF, then word B=0x0) -> Y stays 0xF, Y_VALID=1, OVERRUN=1 after B completes; CLR_OVR pulse -> OVERRUN=0, Y still 0xF.
4. Y_READY=1 held, continuous EN with 12 samples -> three words, Y_VALID pulses each exactly once, no gaps or drops, OVERRUN=0.
5. Send 2 samples (1,1), then SOF=1 with DIN=0 followed by 0,1,0 -> Y=4'b0100; the partial word is never presented.
6. WIDTH=8, LANES=3, send 0xAA,0xBB,0xCC -> Y=24'hCCBBAA; assert RST mid-frame after 2 samples -> Y=0, Y_VALID=0, SLOT=0 immediately (async), and the next 3 samples form a fresh word.
